// File: rtl/md4_pkg.sv
// Shared definitions for the iterative MD4 round engine.
// Holds the MD4 initial chaining values, the per-round additive constants,
// the per-round shift and message-word tables, the engine FSM state type and
// the 32-bit rotate helper used by the step datapath.
package md4_pkg;

  // Standard MD4 initial chaining values (word A is the least significant).
  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hEFCDAB89;
  localparam logic [31:0] IV_C = 32'h98BADCFE;
  localparam logic [31:0] IV_D = 32'h10325476;

  // Additive constants for rounds 1, 2 and 3.
  localparam logic [31:0] K1 = 32'h00000000;
  localparam logic [31:0] K2 = 32'h5A827999;
  localparam logic [31:0] K3 = 32'h6ED9EBA1;

  // Shift tables, four 5-bit entries each; entry n sits at bits [5n +: 5].
  localparam logic [19:0] S1_TABLE = {5'd19, 5'd11, 5'd7, 5'd3};
  localparam logic [19:0] S2_TABLE = {5'd13, 5'd9,  5'd5, 5'd3};
  localparam logic [19:0] S3_TABLE = {5'd15, 5'd11, 5'd9, 5'd3};

  // Message-word order for rounds 2 and 3; entry j sits at bits [4j +: 4].
  // Round 1 uses the identity order, so it needs no table.
  localparam logic [63:0] X2_TABLE = 64'hFB73EA62D951C840;
  localparam logic [63:0] X3_TABLE = 64'hF7B3D591E6A2C480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } fsm_state_t;

  // Rotate left; shifting a doubled copy avoids a special case for s = 0.
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] dbl;
    dbl = {x, x} << s;
    return dbl[63:32];
  endfunction

  // Shift amount for a step, selected by round and by the low two bits of j.
  function automatic logic [4:0] shift_amt(input logic [1:0] round_sel, input logic [1:0] j_lo);
    logic [4:0] s;
    case (round_sel)
      2'd1:    s = S2_TABLE[{j_lo, 2'b00} + {3'b000, j_lo} +: 5];
      2'd2:    s = S3_TABLE[{j_lo, 2'b00} + {3'b000, j_lo} +: 5];
      default: s = S1_TABLE[{j_lo, 2'b00} + {3'b000, j_lo} +: 5];
    endcase
    return s;
  endfunction

  // Index of the message word consumed at step j of the given round.
  function automatic logic [3:0] word_index(input logic [1:0] round_sel, input logic [3:0] j);
    logic [3:0] k;
    case (round_sel)
      2'd1:    k = X2_TABLE[{j, 2'b00} +: 4];
      2'd2:    k = X3_TABLE[{j, 2'b00} +: 4];
      default: k = j;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/md4_step.sv
// One combinational MD4 step: t = rotl32(a + fn(b,c,d) + x + K, s).
// Ports:
//   a, b, c, d  - current working words
//   x           - selected message word X[k]
//   round_sel   - 0: F / K1, 1: G / K2, 2: H / K3
//   s           - rotate amount
//   t           - new value that replaces b in the engine's word rotation
module md4_step
  import md4_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] x,
  input  logic [1:0]  round_sel,
  input  logic [4:0]  s,
  output logic [31:0] t
);

  logic [31:0] fn_val;
  logic [31:0] k_val;
  logic [31:0] sum;

  always_comb begin
    fn_val = (b & c) | (~b & d);
    k_val  = K1;
    case (round_sel)
      2'd1: begin
        fn_val = (b & c) | (b & d) | (c & d);
        k_val  = K2;
      end
      2'd2: begin
        fn_val = b ^ c ^ d;
        k_val  = K3;
      end
      default: begin
        fn_val = (b & c) | (~b & d);
        k_val  = K1;
      end
    endcase
  end

  assign sum = a + fn_val + x + k_val;
  assign t   = rotl32(sum, s);

endmodule

// File: rtl/md4_round_engine.sv
// Iterative MD4 round engine: runs rounds 1..NUM_ROUNDS over one 512-bit
// block, one step per clock, through a single shared md4_step datapath.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   start       - request, accepted only while ready is high
//   state_in    - chaining state {D,C,B,A}
//   block_in    - message block, word j at [32j +: 32]
//   ready       - engine idle
//   done        - one-cycle pulse when state_out is updated
//   state_out   - result {D,C,B,A}, held until the next completion
module md4_round_engine
  import md4_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = 3,
  parameter int unsigned FEEDFORWARD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         done,
  output logic [127:0] state_out
);

  localparam logic [5:0] LAST_STEP = 6'(16 * NUM_ROUNDS - 1);

  fsm_state_t   state_reg, state_next;
  logic [5:0]   step_reg;
  logic [31:0]  a_reg, b_reg, c_reg, d_reg;
  logic [127:0] iv_reg;
  logic [511:0] block_reg;
  logic [127:0] state_out_reg;
  logic         done_reg;

  logic [1:0]   round_sel;
  logic [3:0]   j_idx;
  logic [3:0]   k_idx;
  logic [4:0]   shift;
  logic [31:0]  x_word;
  logic [31:0]  t_word;
  logic [127:0] work;
  logic [127:0] result;

  // Step index i = 16*r + j, so the round and in-round index are bit fields.
  assign round_sel = step_reg[5:4];
  assign j_idx     = step_reg[3:0];
  assign k_idx     = word_index(round_sel, j_idx);
  assign shift     = shift_amt(round_sel, j_idx[1:0]);
  assign x_word    = block_reg[{k_idx, 5'b00000} +: 32];

  md4_step u_step (
    .a         (a_reg),
    .b         (b_reg),
    .c         (c_reg),
    .d         (d_reg),
    .x         (x_word),
    .round_sel (round_sel),
    .s         (shift),
    .t         (t_word)
  );

  // After a multiple of four steps the word rotation is back to its
  // starting alignment, so a_reg holds A again.
  assign work = {d_reg, c_reg, b_reg, a_reg};

  for (genvar gi = 0; gi < 4; gi++) begin : g_result
    if (FEEDFORWARD != 0) begin : g_ff
      assign result[32*gi +: 32] = work[32*gi +: 32] + iv_reg[32*gi +: 32];
    end else begin : g_raw
      assign result[32*gi +: 32] = work[32*gi +: 32];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (step_reg == LAST_STEP) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      c_reg         <= '0;
      d_reg         <= '0;
      iv_reg        <= '0;
      block_reg     <= '0;
      state_out_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= state_in[31:0];
            b_reg     <= state_in[63:32];
            c_reg     <= state_in[95:64];
            d_reg     <= state_in[127:96];
            iv_reg    <= state_in;
            block_reg <= block_in;
            step_reg  <= '0;
          end
        end
        RUN: begin
          a_reg    <= d_reg;
          b_reg    <= t_word;
          c_reg    <= b_reg;
          d_reg    <= c_reg;
          step_reg <= step_reg + 6'd1;
        end
        FIN: begin
          state_out_reg <= result;
          done_reg      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state_reg == IDLE);
  assign done      = done_reg;
  assign state_out = state_out_reg;

endmodule

// File: tb/tb_md4_round_engine.sv
// Self-checking bench for md4_round_engine: one 3-round feed-forward
// instance and one 1-round raw instance, checked against a word-array MD4
// reference model plus the known empty-message and "abc" digests.
module tb_md4_round_engine;
  import md4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start3, start1;
  logic [127:0] state_in3, state_in1;
  logic [511:0] block_in3, block_in1;
  logic         ready3, ready1, done3, done1;
  logic [127:0] state_out3, state_out1;

  md4_round_engine #(.NUM_ROUNDS(3), .FEEDFORWARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start3), .state_in(state_in3),
    .block_in(block_in3), .ready(ready3), .done(done3), .state_out(state_out3)
  );

  md4_round_engine #(.NUM_ROUNDS(1), .FEEDFORWARD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .state_in(state_in1),
    .block_in(block_in1), .ready(ready1), .done(done1), .state_out(state_out1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Reference MD4: four words in an array; step i updates word (-i mod 4)
  // using the three that follow it cyclically.
  function automatic logic [127:0] md4_model(input logic [127:0] st, input logic [511:0] blk,
                                             input int rounds, input bit ff);
    logic [31:0] h[4];
    logic [31:0] xw[16];
    logic [31:0] kc[3];
    int sh[3][4];
    logic [31:0] fb, fc, fd, f;
    logic [127:0] r;
    int p, rd, j, k;
    kc = '{32'h0, 32'h5A827999, 32'h6ED9EBA1};
    sh = '{'{3, 7, 11, 19}, '{3, 5, 9, 13}, '{3, 9, 11, 15}};
    for (int w = 0; w < 4; w++) h[w] = st[32*w +: 32];
    for (int w = 0; w < 16; w++) xw[w] = blk[32*w +: 32];
    for (int i = 0; i < 16 * rounds; i++) begin
      rd = i / 16;
      j  = i % 16;
      p  = (4 - (i % 4)) % 4;
      fb = h[(p + 1) % 4];
      fc = h[(p + 2) % 4];
      fd = h[(p + 3) % 4];
      if (rd == 0) begin
        f = (fb & fc) | (~fb & fd);
        k = j;
      end else if (rd == 1) begin
        f = (fb & fc) | (fb & fd) | (fc & fd);
        k = (j % 4) * 4 + j / 4;
      end else begin
        f = fb ^ fc ^ fd;
        k = ((j & 1) << 3) | ((j & 2) << 1) | ((j & 4) >> 1) | ((j & 8) >> 3);
      end
      h[p] = rl(h[p] + f + xw[k] + kc[rd], sh[rd][j % 4]);
    end
    for (int w = 0; w < 4; w++) r[32*w +: 32] = ff ? h[w] + st[32*w +: 32] : h[w];
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Starts an operation at the current negedge and waits for done.
  // Inputs are scrambled after capture; with spam set, start stays high
  // with fresh blocks while busy. state_out must hold prev until done.
  task automatic run_op(input bit which, input logic [127:0] st, input logic [511:0] blk,
                        input bit spam, input logic [127:0] prev,
                        output logic [127:0] res, output int lat);
    bit held_ok;
    logic dn;
    logic [127:0] so;
    held_ok = 1'b1;
    lat = 0;
    if (which) begin start1 = 1'b1; state_in1 = st; block_in1 = blk; end
    else       begin start3 = 1'b1; state_in3 = st; block_in3 = blk; end
    forever begin
      @(negedge clk);
      lat++;
      dn = which ? done1 : done3;
      so = which ? state_out1 : state_out3;
      if (dn || lat >= 300) break;
      if (so !== prev) held_ok = 1'b0;
      if (which) begin start1 = spam; state_in1 = rnd128(); block_in1 = rnd512(); end
      else       begin start3 = spam; state_in3 = rnd128(); block_in3 = rnd512(); end
    end
    start1 = 1'b0;
    start3 = 1'b0;
    res = which ? state_out1 : state_out3;
    check_eq("hold", {159'b0, held_ok}, 160'd1);
  endtask

  logic [127:0] iv_vec, exp_v, res, prev3, prev1;
  logic [511:0] blk;
  int lat, spur;

  initial begin
    iv_vec = {IV_D, IV_C, IV_B, IV_A};
    rst_n = 1'b0;
    start3 = 1'b0; start1 = 1'b0;
    state_in3 = '0; state_in1 = '0; block_in3 = '0; block_in1 = '0;
    repeat (3) @(negedge clk);
    check_eq("reset3", {30'b0, ready3, done3, state_out3}, {30'b0, 1'b1, 1'b0, 128'b0});
    check_eq("reset1", {30'b0, ready1, done1, state_out1}, {30'b0, 1'b1, 1'b0, 128'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // Empty message.
    blk = '0; blk[31:0] = 32'h00000080;
    run_op(1'b0, iv_vec, blk, 1'b0, 128'b0, res, lat);
    $display("op empty: lat=%0d out=%h", lat, res);
    check_eq("empty_lat", 160'(lat), 160'd50);
    check_eq("empty_dig", {32'b0, res}, {32'b0, 32'hc089c0e0, 32'hd7593cb7, 32'h31e96ad1, 32'he0cfd631});
    check_eq("empty_model", {32'b0, res}, {32'b0, md4_model(iv_vec, blk, 3, 1'b1)});
    prev3 = res;

    // "abc", started back-to-back in the cycle ready rises.
    blk = '0; blk[31:0] = 32'h80636261; blk[14*32 +: 32] = 32'h00000018;
    run_op(1'b0, iv_vec, blk, 1'b0, prev3, res, lat);
    $display("op abc: lat=%0d out=%h", lat, res);
    check_eq("abc_lat", 160'(lat), 160'd50);
    check_eq("abc_dig", {32'b0, res}, {32'b0, 32'h9d72a67a, 32'he80ac15f, 32'h52d821af, 32'h7a0148a4});
    prev3 = res;

    // start held high with different blocks while busy.
    blk = rnd512(); exp_v = md4_model(iv_vec, blk, 3, 1'b1);
    run_op(1'b0, iv_vec, blk, 1'b1, prev3, res, lat);
    $display("op spam: lat=%0d out=%h exp=%h", lat, res, exp_v);
    check_eq("spam_lat", 160'(lat), 160'd50);
    check_eq("spam_res", {32'b0, res}, {32'b0, exp_v});
    @(negedge clk);
    check_eq("spam_idle", {158'b0, ready3, done3}, {158'b0, 2'b10});
    prev3 = res;

    // Random states and blocks on the 3-round engine.
    for (int it = 0; it < 20; it++) begin
      iv_vec = rnd128(); blk = rnd512(); exp_v = md4_model(iv_vec, blk, 3, 1'b1);
      run_op(1'b0, iv_vec, blk, 1'b0, prev3, res, lat);
      $display("op r3 #%0d: lat=%0d out=%h exp=%h", it, lat, res, exp_v);
      check_eq("r3_lat", 160'(lat), 160'd50);
      check_eq("r3_res", {32'b0, res}, {32'b0, exp_v});
      prev3 = exp_v;
    end
    iv_vec = {IV_D, IV_C, IV_B, IV_A};

    // Reset pulse just before step 20 executes.
    start3 = 1'b1; state_in3 = iv_vec; block_in3 = rnd512();
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start3 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_out", {30'b0, ready3, done3, state_out3}, {30'b0, 1'b1, 1'b0, 128'b0});
    rst_n = 1'b1;
    spur = 0;
    repeat (60) begin
      @(negedge clk);
      if (done3) spur++;
    end
    check_eq("midrst_nodone", 160'(spur), 160'd0);
    blk = '0; blk[31:0] = 32'h00000080;
    run_op(1'b0, iv_vec, blk, 1'b0, 128'b0, res, lat);
    $display("op post-reset empty: lat=%0d out=%h", lat, res);
    check_eq("midrst_lat", 160'(lat), 160'd50);
    check_eq("midrst_dig", {32'b0, res}, {32'b0, 32'hc089c0e0, 32'hd7593cb7, 32'h31e96ad1, 32'he0cfd631});

    // One-round raw engine, back-to-back random operations.
    prev1 = '0;
    for (int it = 0; it < 1000; it++) begin
      iv_vec = rnd128(); blk = rnd512(); exp_v = md4_model(iv_vec, blk, 1, 1'b0);
      run_op(1'b1, iv_vec, blk, 1'b0, prev1, res, lat);
      $display("op r1 #%0d: lat=%0d out=%h exp=%h", it, lat, res, exp_v);
      check_eq("r1_lat", 160'(lat), 160'd18);
      check_eq("r1_res", {32'b0, res}, {32'b0, exp_v});
      prev1 = exp_v;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
